// File: rtl/sha1_msg_padder_if.sv
// Byte-granular message word stream into the SHA-1 padder.
// The source drives valid/data/last/bytes; the padder returns ready.
interface sha1_msg_padder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  in_bytes;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output in_bytes,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  in_bytes,
        output in_ready
    );
endinterface

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: packs a big-endian word stream into 512-bit blocks,
// appends 0x80 / zero fill / 64-bit bit length and hands each block to the
// core, holding it stable until the core signals completion.
module sha1_msg_padder (
    input  logic              clk,
    input  logic              reset,
    sha1_msg_padder_if.slave  s_in,
    output logic [15:0][31:0] block_o,
    output logic              start_o,
    output logic              use_prev_cv_o,
    input  logic              done_i,
    output logic [15:0]       blk_cnt_o,
    output logic              msg_done_o
);

    typedef enum logic [2:0] {
        S_FILL,
        S_PAD,
        S_LEN,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [15:0][31:0]  r_block;
    logic [4:0]         r_wptr;
    logic [63:0]        r_bit_len;
    logic [15:0]        r_blk_cnt;
    logic               r_final;       // length field is in the current block
    logic               r_ended;       // last message word already consumed
    logic               r_pad_pending; // 0x80 marker still has to be written
    logic               r_use_prev;
    logic               r_rst_hold;    // keeps in_ready low for the first cycle after reset

    logic               w_in_ready;
    logic               w_accept;
    logic               w_pad_wr;
    logic               w_len_wr;
    logic               w_done_ok;
    logic [2:0]         w_nbytes;
    logic [31:0]        w_word;

    assign s_in.in_ready = w_in_ready;
    assign block_o       = r_block;
    assign use_prev_cv_o = r_use_prev;
    assign blk_cnt_o     = r_blk_cnt;

    // Effective byte count and padded form of the incoming word.
    always_comb begin
        w_nbytes = 3'd4;
        if (s_in.in_last) begin
            w_nbytes = (s_in.in_bytes > 3'd4) ? 3'd4 : s_in.in_bytes;
        end
        w_word = s_in.in_data;
        if (s_in.in_last) begin
            case (w_nbytes)
                3'd0:    w_word = 32'h8000_0000;
                3'd1:    w_word = {s_in.in_data[31:24], 8'h80, 16'h0000};
                3'd2:    w_word = {s_in.in_data[31:16], 8'h80, 8'h00};
                3'd3:    w_word = {s_in.in_data[31:8], 8'h80};
                default: w_word = s_in.in_data;
            endcase
        end
    end

    // Next-state and control strobes.
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_accept   = 1'b0;
        w_pad_wr   = 1'b0;
        w_len_wr   = 1'b0;
        w_done_ok  = 1'b0;
        start_o    = 1'b0;
        msg_done_o = 1'b0;
        case (r_state)
            S_FILL: begin
                w_in_ready = ~r_rst_hold;
                w_accept   = s_in.in_valid & w_in_ready;
                if (w_accept) begin
                    if (s_in.in_last) begin
                        w_next = S_PAD;
                    end else if (r_wptr == 5'd15) begin
                        w_next = S_ISSUE;
                    end
                end
            end
            S_PAD: begin
                // Length fits only once the marker is placed and words 14/15 are free.
                if (r_wptr[4]) begin
                    w_next = S_ISSUE;
                end else if ((r_wptr == 5'd14) && !r_pad_pending) begin
                    w_next = S_LEN;
                end else begin
                    w_pad_wr = 1'b1;
                end
            end
            S_LEN: begin
                w_len_wr = 1'b1;
                w_next   = S_ISSUE;
            end
            S_ISSUE: begin
                start_o = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                if (done_i) begin
                    w_done_ok  = 1'b1;
                    msg_done_o = r_final;
                    if (r_final || !r_ended) begin
                        w_next = S_FILL;
                    end else begin
                        w_next = S_PAD;
                    end
                end
            end
            default: w_next = S_FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    // Block buffer, pointers, length accumulator and block bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_block       <= '0;
            r_wptr        <= '0;
            r_bit_len     <= '0;
            r_blk_cnt     <= '0;
            r_final       <= 1'b0;
            r_ended       <= 1'b0;
            r_pad_pending <= 1'b0;
            r_use_prev    <= 1'b0;
            r_rst_hold    <= 1'b1;
        end else begin
            r_rst_hold <= 1'b0;
            if (w_accept) begin
                r_block[r_wptr[3:0]] <= w_word;
                r_wptr               <= r_wptr + 5'd1;
                r_bit_len            <= r_bit_len + {58'd0, w_nbytes, 3'b000};
                if (s_in.in_last) begin
                    r_ended       <= 1'b1;
                    r_pad_pending <= (w_nbytes == 3'd4);
                end
            end
            if (w_pad_wr) begin
                r_block[r_wptr[3:0]] <= r_pad_pending ? 32'h8000_0000 : 32'h0000_0000;
                r_pad_pending        <= 1'b0;
                r_wptr               <= r_wptr + 5'd1;
            end
            if (w_len_wr) begin
                r_block[14] <= r_bit_len[63:32];
                r_block[15] <= r_bit_len[31:0];
                r_final     <= 1'b1;
            end
            if (w_next == S_ISSUE) begin
                r_use_prev <= (r_blk_cnt != 16'd0);
            end
            if (r_state == S_ISSUE) begin
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end
            if (w_done_ok) begin
                r_wptr <= '0;
                if (r_final) begin
                    r_blk_cnt     <= '0;
                    r_bit_len     <= '0;
                    r_final       <= 1'b0;
                    r_ended       <= 1'b0;
                    r_pad_pending <= 1'b0;
                end else begin
                    r_block <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Directed bench for sha1_msg_padder: a byte-level FIPS 180-4 padding model
// supplies expected blocks; a small core model answers start with done.
module tb_sha1_msg_padder;

    logic              clk = 1'b0;
    logic              reset;
    logic              done_i;
    logic [15:0][31:0] block_o;
    logic              start_o;
    logic              use_prev_cv_o;
    logic [15:0]       blk_cnt_o;
    logic              msg_done_o;

    sha1_msg_padder_if ifc();

    sha1_msg_padder dut (
        .clk           (clk),
        .reset         (reset),
        .s_in          (ifc),
        .block_o       (block_o),
        .start_o       (start_o),
        .use_prev_cv_o (use_prev_cv_o),
        .done_i        (done_i),
        .blk_cnt_o     (blk_cnt_o),
        .msg_done_o    (msg_done_o)
    );

    always #5 clk = ~clk;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    typedef struct {
        int          nbytes;
        int          nblk;
        int          dly;
        logic [31:0] w15;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference padding done on a byte list, then split into words.
    function automatic wq_t pad_model(input bq_t m);
        bq_t         p;
        wq_t         w;
        logic [63:0] len;
        p   = m;
        len = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(len[i*8 +: 8]);
        for (int i = 0; i < p.size(); i += 4) w.push_back({p[i], p[i+1], p[i+2], p[i+3]});
        return w;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int t = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ifc.in_last  = last;
        ifc.in_bytes = nb;
        #1;
        while (!ifc.in_ready && t < 800) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!ifc.in_ready) chk("in_ready_timeout", 1'b0, 1'b1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    // Unused low bytes of the last word carry 0xA5 so zeroing is exercised;
    // non-last words carry in_bytes=1, which the padder must ignore.
    task automatic send_msg(input bq_t m);
        int n  = m.size();
        int nw = (n == 0) ? 1 : (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            int          rem = n - 4 * w;
            logic        last = (w == nw - 1);
            for (int k = 0; k < 4; k++) begin
                if (k < rem) d[31-8*k -: 8] = m[4*w+k];
                else         d[31-8*k -: 8] = 8'hA5;
            end
            send_word(d, last, last ? 3'(rem) : 3'd1);
        end
    endtask

    task automatic core_check(input string nm, input wq_t exp, input int nb, input int dly,
                              output logic [511:0] last_blk);
        logic [511:0] cap;
        logic [511:0] expb;
        logic         stray;
        cap = '0;
        for (int b = 0; b < nb; b++) begin
            int t = 0;
            while (!start_o && t < 800) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("%s_start_b%0d", nm, b), start_o, 1'b1);
            if (!start_o) begin
                last_blk = cap;
                return;
            end
            for (int i = 0; i < 16; i++) expb[32*i +: 32] = exp[16*b+i];
            chk($sformatf("%s_block_b%0d", nm, b), block_o, expb);
            chk($sformatf("%s_use_prev_b%0d", nm, b), use_prev_cv_o, (b != 0));
            cap = block_o;
            // done_i (possibly still high from the previous block) spans the issue edge
            @(negedge clk);
            done_i = 1'b0;
            stray  = 1'b0;
            repeat (dly) begin
                @(negedge clk);
                if (start_o) stray = 1'b1;
            end
            chk($sformatf("%s_no_start_in_wait_b%0d", nm, b), stray, 1'b0);
            done_i = 1'b1;
            #1;
            chk($sformatf("%s_block_stable_b%0d", nm, b), block_o, cap);
            chk($sformatf("%s_blk_cnt_b%0d", nm, b), blk_cnt_o, 16'(b + 1));
            chk($sformatf("%s_msg_done_b%0d", nm, b), msg_done_o, (b == nb - 1));
            @(negedge clk);
            if (b == nb - 1) begin
                chk($sformatf("%s_msg_done_pulse", nm), msg_done_o, 1'b0);
                chk($sformatf("%s_blk_cnt_clear", nm), blk_cnt_o, 16'd0);
            end
        end
        last_blk = cap;
    endtask

    task automatic run_msg(input string nm, input bq_t m, input int nb, input int dly,
                           input logic [31:0] w15, output logic [511:0] lb);
        wq_t  e;
        logic stray;
        e = pad_model(m);
        fork
            send_msg(m);
            core_check(nm, e, nb, dly, lb);
        join
        chk({nm, "_final_w15"}, lb[511:480], w15);
        stray = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (start_o) stray = 1'b1;
        end
        chk({nm, "_no_extra_start"}, stray, 1'b0);
    endtask

    initial begin
        vec_t         tbl[12];
        bq_t          m;
        logic [511:0] lb;
        logic         stray;

        tbl[0]  = '{nbytes: 0,   nblk: 1, dly: 1, w15: 32'h0000_0000};
        tbl[1]  = '{nbytes: 3,   nblk: 1, dly: 0, w15: 32'h0000_0018};
        tbl[2]  = '{nbytes: 4,   nblk: 1, dly: 2, w15: 32'h0000_0020};
        tbl[3]  = '{nbytes: 55,  nblk: 1, dly: 3, w15: 32'h0000_01B8};
        tbl[4]  = '{nbytes: 56,  nblk: 2, dly: 1, w15: 32'h0000_01C0};
        tbl[5]  = '{nbytes: 60,  nblk: 2, dly: 0, w15: 32'h0000_01E0};
        tbl[6]  = '{nbytes: 63,  nblk: 2, dly: 4, w15: 32'h0000_01F8};
        tbl[7]  = '{nbytes: 64,  nblk: 2, dly: 2, w15: 32'h0000_0200};
        tbl[8]  = '{nbytes: 65,  nblk: 2, dly: 1, w15: 32'h0000_0208};
        tbl[9]  = '{nbytes: 119, nblk: 2, dly: 3, w15: 32'h0000_03B8};
        tbl[10] = '{nbytes: 120, nblk: 3, dly: 0, w15: 32'h0000_03C0};
        tbl[11] = '{nbytes: 128, nblk: 3, dly: 2, w15: 32'h0000_0400};

        reset        = 1'b1;
        done_i       = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
        ifc.in_last  = 1'b0;
        ifc.in_bytes = '0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", ifc.in_ready, 1'b0);
        chk("rst_start", start_o, 1'b0);
        chk("rst_use_prev", use_prev_cv_o, 1'b0);
        chk("rst_msg_done", msg_done_o, 1'b0);
        chk("rst_blk_cnt", blk_cnt_o, 16'd0);
        chk("rst_block", block_o, 512'd0);
        reset = 1'b0;
        #1;
        chk("ready_low_first_cycle", ifc.in_ready, 1'b0);
        @(negedge clk);
        chk("ready_high_after", ifc.in_ready, 1'b1);

        // "abc"
        m = {8'h61, 8'h62, 8'h63};
        run_msg("abc", m, 1, 3, 32'h0000_0018, lb);
        chk("abc_w0", lb[31:0], 32'h6162_6380);
        chk("abc_w1_14_zero", lb[479:32], 448'd0);

        // empty message
        m = {};
        run_msg("empty", m, 1, 2, 32'h0000_0000, lb);
        chk("empty_w0", lb[31:0], 32'h8000_0000);

        for (int v = 0; v < 12; v++) begin
            m = {};
            for (int k = 0; k < tbl[v].nbytes; k++) m.push_back(8'(k * 37 + v * 11 + 5));
            run_msg($sformatf("vec%0d_len%0d", v, tbl[v].nbytes), m, tbl[v].nblk, tbl[v].dly,
                    tbl[v].w15, lb);
        end

        // reset while the first block of a long message is outstanding
        for (int w = 0; w < 16; w++) send_word(32'h1000_0000 + 32'(w), 1'b0, 3'd2);
        begin
            int t = 0;
            while (!start_o && t < 100) begin
                @(negedge clk);
                t++;
            end
        end
        chk("rstw_start_seen", start_o, 1'b1);
        chk("rstw_use_prev", use_prev_cv_o, 1'b0);
        chk("rstw_w15", block_o[15], 32'h1000_000F);
        @(negedge clk);
        done_i = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstw_start", start_o, 1'b0);
        chk("rstw_blk_cnt", blk_cnt_o, 16'd0);
        chk("rstw_block", block_o, 512'd0);
        chk("rstw_msg_done", msg_done_o, 1'b0);
        chk("rstw_use_prev_clr", use_prev_cv_o, 1'b0);
        chk("rstw_in_ready", ifc.in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        done_i = 1'b1;
        #1;
        chk("rstw_ready_low_first", ifc.in_ready, 1'b0);
        stray = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (start_o || msg_done_o) stray = 1'b1;
        end
        chk("rstw_no_start_after", stray, 1'b0);
        chk("rstw_ready_back", ifc.in_ready, 1'b1);

        m = {8'h61, 8'h62, 8'h63};
        run_msg("abc_after_rst", m, 1, 1, 32'h0000_0018, lb);
        chk("abc_after_rst_w0", lb[31:0], 32'h6162_6380);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
